// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: NPASS=WIDTH/DIGIT cycles per op, result held in DONE until out_ready.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NPASS = WIDTH / DIGIT;
  localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NPASS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;
  logic [WIDTH-1:0] res_nxt;

  // One DIGIT-wide ripple slice; c[DIGIT-1] is the carry into the digit's top bit.
  always_comb begin
    da      = a_r[cnt*DIGIT +: DIGIT];
    db      = b_r[cnt*DIGIT +: DIGIT];
    dsum    = '0;
    c       = '0;
    c[0]    = carry;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]  = da[i] ^ db[i] ^ c[i];
      c[i+1]   = (da[i] & db[i]) | (c[i] & (da[i] ^ db[i]));
    end
    res_nxt = res;
    res_nxt[cnt*DIGIT +: DIGIT] = dsum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      res       <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Subtract as A + ~B + 1: the +1 enters through the initial carry.
            a_r      <= a;
            b_r      <= sub ? ~b : b;
            carry    <= sub;
            cnt      <= '0;
            res      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          carry <= c[DIGIT];
          res   <= res_nxt;
          if (cnt == LAST) begin
            sum       <= {c[DIGIT], res_nxt};
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf       <= c[DIGIT] ^ c[DIGIT-1];
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf       <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub over three geometries: W4/D1, W8/D4, W8/D1.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       iv_a = 0, ir_a, sb_a = 0, ov_a, or_a = 0;
  logic [3:0] a_a = 0, b_a = 0;
  logic [4:0] s_a;
  logic       iv_b = 0, ir_b, sb_b = 0, ov_b, or_b = 0;
  logic [7:0] a_b = 0, b_b = 0;
  logic [8:0] s_b;
  logic       iv_c = 0, ir_c, sb_c = 0, ov_c, or_c = 0;
  logic [7:0] a_c = 0, b_c = 0;
  logic [8:0] s_c;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_a, ovf_b, ovf_c;
`endif

  serial_addsub #(.WIDTH(4), .DIGIT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .a(a_a), .b(b_a),
    .sub(sb_a), .out_valid(ov_a), .out_ready(or_a), .sum(s_a)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .ovf(ovf_a)
`endif
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .a(a_b), .b(b_b),
    .sub(sb_b), .out_valid(ov_b), .out_ready(or_b), .sum(s_b)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .ovf(ovf_b)
`endif
  );

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .a(a_c), .b(b_c),
    .sub(sb_c), .out_valid(ov_c), .out_ready(or_c), .sum(s_c)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .ovf(ovf_c)
`endif
  );

  // Drivers only: present one operand pair, then count edges until out_valid (bounded).
  task automatic run_a(input logic [3:0] av, input logic [3:0] bv, input logic sv,
                       output logic [4:0] res, output logic ofl, output int lat);
    iv_a = 1'b1; a_a = av; b_a = bv; sb_a = sv;
    @(posedge clk); #1;
    iv_a = 1'b0; a_a = 'x; b_a = 'x; sb_a = 1'bx;
    lat = 0;
    while (ov_a !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    res = s_a;
`ifdef SERIAL_ADDSUB_OVF_EN
    ofl = ovf_a;
`else
    ofl = 1'b0;
`endif
  endtask

  task automatic run_b(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                       output logic [8:0] res, output int lat);
    iv_b = 1'b1; a_b = av; b_b = bv; sb_b = sv;
    @(posedge clk); #1;
    iv_b = 1'b0; a_b = 'x; b_b = 'x; sb_b = 1'bx;
    lat = 0;
    while (ov_b !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    res = s_b;
  endtask

  task automatic run_c(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                       output logic [8:0] res, output int lat);
    iv_c = 1'b1; a_c = av; b_c = bv; sb_c = sv;
    @(posedge clk); #1;
    iv_c = 1'b0; a_c = 'x; b_c = 'x; sb_c = 1'bx;
    lat = 0;
    while (ov_c !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    res = s_c;
  endtask

  task automatic release_a(); or_a = 1'b1; @(posedge clk); #1; or_a = 1'b0; endtask
  task automatic release_b(); or_b = 1'b1; @(posedge clk); #1; or_b = 1'b0; endtask
  task automatic release_c(); or_c = 1'b1; @(posedge clk); #1; or_c = 1'b0; endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if ({ir_a, ov_a, s_a} !== {1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL reset_a: ir/ov/sum=%b/%b/%h required 1/0/00", ir_a, ov_a, s_a);
    end
    checks++;
    if ({ir_b, ov_b, s_b, ir_c, ov_c, s_c} !== {1'b1, 1'b0, 9'd0, 1'b1, 1'b0, 9'd0}) begin
      errors++; $display("FAIL reset_bc: b=%b/%b/%h c=%b/%b/%h required 1/0/000", ir_b, ov_b, s_b, ir_c, ov_c, s_c);
    end
`ifdef SERIAL_ADDSUB_OVF_EN
    checks++;
    if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf: ovf=%b required 0", ovf_a); end
`endif
  endtask

  task automatic test_add_w4();
    logic [4:0] r; logic o; int lat;
    checks++;
    if (ir_a !== 1'b1) begin errors++; $display("FAIL add_w4_ready: in_ready=%b required 1", ir_a); end
    run_a(4'd9, 4'd7, 1'b0, r, o, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL add_w4_latency: %0d cycles required 4", lat); end
    checks++;
    if (r !== 5'b1_0000) begin errors++; $display("FAIL add_w4_sum: sum=%b required 10000", r); end
    checks++;
    if (ir_a !== 1'b0) begin errors++; $display("FAIL add_w4_busy: in_ready=%b in DONE required 0", ir_a); end
    release_a();
    checks++;
    if ({ov_a, ir_a} !== 2'b01) begin
      errors++; $display("FAIL add_w4_release: out_valid/in_ready=%b%b required 01", ov_a, ir_a);
    end
  endtask

  task automatic test_sub_w4();
    logic [4:0] r; logic o; int lat;
    run_a(4'd5, 4'd7, 1'b1, r, o, lat);
    checks++;
    if (r !== 5'b0_1110) begin errors++; $display("FAIL sub_borrow: sum=%b required 01110", r); end
    release_a();
    run_a(4'd7, 4'd5, 1'b1, r, o, lat);
    checks++;
    if (r !== 5'b1_0010) begin errors++; $display("FAIL sub_noborrow: sum=%b required 10010", r); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL sub_latency: %0d cycles required 4", lat); end
    release_a();
  endtask

  task automatic test_digit4();
    logic [8:0] r; int lat;
    run_b(8'd255, 8'd1, 1'b0, r, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL d4_latency: %0d cycles required 2", lat); end
    checks++;
    if (r !== 9'h100) begin errors++; $display("FAIL d4_wrap: sum=%h required 100", r); end
    release_b();
    run_b(8'h3C, 8'hC5, 1'b1, r, lat);
    checks++;
    if (r !== 9'h077) begin errors++; $display("FAIL d4_sub: sum=%h required 077", r); end
    release_b();
    run_b(8'h9A, 8'h76, 1'b0, r, lat);
    checks++;
    if (r !== 9'h110) begin errors++; $display("FAIL d4_add: sum=%h required 110", r); end
    release_b();
  endtask

  task automatic test_hold();
    logic [4:0] r; logic o; int lat;
    run_a(4'd2, 4'd3, 1'b0, r, o, lat);
    for (int i = 0; i < 10; i++) begin
      iv_a = (i % 2 == 0); a_a = 4'd15; b_a = 4'd15; sb_a = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({ov_a, ir_a, s_a} !== {1'b1, 1'b0, 5'd5}) begin
        errors++; $display("FAIL hold_cycle%0d: ov/ir/sum=%b/%b/%h required 1/0/05", i, ov_a, ir_a, s_a);
      end
    end
    iv_a = 1'b0;
    release_a();
    checks++;
    if ({ov_a, ir_a} !== 2'b01) begin
      errors++; $display("FAIL hold_release: out_valid/in_ready=%b%b required 01", ov_a, ir_a);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (ov_a !== 1'b0) begin errors++; $display("FAIL hold_ignored_pulse: out_valid=%b required 0", ov_a); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] r; logic o; int lat;
    run_a(4'd15, 4'd15, 1'b0, r, o, lat);
    checks++;
    if (r !== 5'b1_1110) begin errors++; $display("FAIL b2b_first: sum=%b required 11110", r); end
    release_a();
    run_a(4'd0, 4'd0, 1'b1, r, o, lat);
    checks++;
    if (r !== 5'b1_0000 || lat !== 4) begin
      errors++; $display("FAIL b2b_second: sum=%b lat=%0d required 10000 lat 4", r, lat);
    end
    release_a();
  endtask

  task automatic test_reset_midop();
    logic [8:0] r; int lat;
    run_c(8'd200, 8'd100, 1'b0, r, lat);
    checks++;
    if (r !== 9'h12C || lat !== 8) begin
      errors++; $display("FAIL midop_pre: sum=%h lat=%0d required 12C lat 8", r, lat);
    end
    release_c();
    iv_c = 1'b1; a_c = 8'd50; b_c = 8'd60; sb_c = 1'b0;
    @(posedge clk); #1;
    iv_c = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({ir_c, ov_c, s_c} !== {1'b1, 1'b0, 9'd0}) begin
      errors++; $display("FAIL midop_reset: ir/ov/sum=%b/%b/%h required 1/0/000", ir_c, ov_c, s_c);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (ov_c !== 1'b0) begin errors++; $display("FAIL midop_abort: out_valid=%b required 0", ov_c); end
    run_c(8'd3, 8'd4, 1'b0, r, lat);
    checks++;
    if (r !== 9'h007 || lat !== 8) begin
      errors++; $display("FAIL midop_after: sum=%h lat=%0d required 007 lat 8", r, lat);
    end
    release_c();
  endtask

`ifdef SERIAL_ADDSUB_OVF_EN
  task automatic test_ovf();
    logic [4:0] r; logic o; int lat;
    run_a(4'd7, 4'd1, 1'b0, r, o, lat);
    checks++;
    if ({o, r} !== {1'b1, 5'b0_1000}) begin errors++; $display("FAIL ovf_7p1: ovf=%b sum=%b required 1 01000", o, r); end
    release_a();
    checks++;
    if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_clear: ovf=%b required 0", ovf_a); end
    run_a(4'b1000, 4'd1, 1'b1, r, o, lat);
    checks++;
    if ({o, r} !== {1'b1, 5'b1_0111}) begin errors++; $display("FAIL ovf_8m1: ovf=%b sum=%b required 1 10111", o, r); end
    release_a();
    run_a(4'd3, 4'd2, 1'b0, r, o, lat);
    checks++;
    if ({o, r} !== {1'b0, 5'b0_0101}) begin errors++; $display("FAIL ovf_3p2: ovf=%b sum=%b required 0 00101", o, r); end
    release_a();
  endtask
`endif

  initial begin
    test_reset();
    test_add_w4();
    test_sub_w4();
    test_digit4();
    test_hold();
    test_back_to_back();
    test_reset_midop();
`ifdef SERIAL_ADDSUB_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
